// File: rtl/crc16_serial_accum.sv
// Serial CRC-16 accumulator: folds one data bit per bit_en cycle into the CRC over a
// frame of frame_len bytes, then holds the result and shifts it out MSB first on crc_en.
module crc16_serial_accum #(
  parameter logic [15:0] POLY  = 16'h1021,
  parameter logic [15:0] INIT  = 16'h0000,
  parameter int          LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             crc_en,
  output logic             busy,
  output logic             crc_valid,
  output logic [15:0]      crc,
  output logic             crc_out,
  output logic             done
);

  localparam int CNT_W = LEN_W + 3;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  // One MSB-first step of the CRC division for a single message bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    crc_step = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  logic [1:0]       state_r,     state_nxt_s;
  logic [15:0]      crc_r,       crc_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r,   bit_cnt_nxt_s;
  logic [LEN_W-1:0] len_r,       len_nxt_s;
  logic [15:0]      emit_sr_r,   emit_sr_nxt_s;
  logic [4:0]       emit_cnt_r,  emit_cnt_nxt_s;
  logic             done_r,      done_nxt_s;
  logic             busy_r,      busy_nxt_s;
  logic             crc_valid_r, crc_valid_nxt_s;
  logic [15:0]      crc_step_s;
  logic [CNT_W-1:0] bit_cnt_inc_s;

  assign crc_step_s    = crc_step(crc_r, bit_in);
  assign bit_cnt_inc_s = bit_cnt_r + CNT_ONE;

  // Next-state and datapath update; start overrides every state.
  always_comb begin
    state_nxt_s    = state_r;
    crc_nxt_s      = crc_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    len_nxt_s      = len_r;
    emit_sr_nxt_s  = emit_sr_r;
    emit_cnt_nxt_s = emit_cnt_r;
    done_nxt_s     = 1'b0;
    if (start) begin
      crc_nxt_s      = INIT;
      bit_cnt_nxt_s  = CNT_ZERO;
      len_nxt_s      = frame_len;
      emit_cnt_nxt_s = 5'd0;
      if (frame_len == {LEN_W{1'b0}}) begin
        state_nxt_s   = ST_HOLD;
        emit_sr_nxt_s = INIT;
      end else begin
        state_nxt_s   = ST_ACCUM;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ACCUM: begin
          if (bit_en) begin
            crc_nxt_s     = crc_step_s;
            bit_cnt_nxt_s = bit_cnt_inc_s;
            if (bit_cnt_inc_s == {len_r, 3'b000}) begin
              state_nxt_s   = ST_HOLD;
              emit_sr_nxt_s = crc_step_s;
            end else begin
              state_nxt_s   = ST_ACCUM;
            end
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (crc_en) begin
            emit_sr_nxt_s  = {emit_sr_r[14:0], 1'b0};
            emit_cnt_nxt_s = 5'd1;
            state_nxt_s    = ST_EMIT;
          end else begin
            state_nxt_s    = ST_HOLD;
          end
        end
        ST_EMIT: begin
          if (crc_en) begin
            emit_sr_nxt_s  = {emit_sr_r[14:0], 1'b0};
            emit_cnt_nxt_s = emit_cnt_r + 5'd1;
            if (emit_cnt_r == 5'd15) begin
              state_nxt_s = ST_IDLE;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_EMIT;
            end
          end else begin
            state_nxt_s = ST_EMIT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    crc_valid_nxt_s = (state_nxt_s == ST_HOLD) || (state_nxt_s == ST_EMIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      crc_r       <= INIT;
      bit_cnt_r   <= CNT_ZERO;
      len_r       <= {LEN_W{1'b0}};
      emit_sr_r   <= 16'h0000;
      emit_cnt_r  <= 5'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      crc_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      crc_r       <= crc_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      len_r       <= len_nxt_s;
      emit_sr_r   <= emit_sr_nxt_s;
      emit_cnt_r  <= emit_cnt_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
      crc_valid_r <= crc_valid_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign crc_valid = crc_valid_r;
  assign crc       = crc_r;
  assign done      = done_r;
  // Serial bit comes straight off the shift register so it tracks each crc_en shift.
  assign crc_out   = crc_valid_r & emit_sr_r[15];

endmodule
